// File: rtl/if_prefetch_queue_if.sv
// Signal bundle for if_prefetch_queue: imem request/response channel, EX redirect and decode handoff.
// Handshakes: a fetch transfers on imem_req&imem_gnt; imem_rvalid returns responses in request
// order; a decode transfer happens on IF_ID_valid&id_ready; no valid waits on its own ready.
interface if_prefetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTarget;
  logic            id_ready;
  logic            IF_ID_valid;
  logic [31:0]     IF_ID_IR;
  logic [XLEN-1:0] IF_ID_PC;
  logic [CW-1:0]   queue_count;

  modport master (
    output imem_req, imem_addr, IF_ID_valid, IF_ID_IR, IF_ID_PC, queue_count,
    input  imem_gnt, imem_rvalid, imem_rdata, PCSrcE, PCTarget, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, IF_ID_valid, IF_ID_IR, IF_ID_PC, queue_count,
    output imem_gnt, imem_rvalid, imem_rdata, PCSrcE, PCTarget, id_ready
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: pipelined imem requests, DEPTH-entry {PC,IR} queue, redirect flush.
// Optional `IF_PERF_CNT_EN adds saturating redirect/stall counters.
module if_prefetch_queue #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                clk,
  input  logic                rst,
  if_prefetch_queue_if.master bus,
  output logic                dbg_state_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_flush_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CW + 1;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [SW-1:0]   drop_total;

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [31:0]     q_ir [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic [XLEN-1:0] fl_pc [DEPTH];
  logic [AW-1:0]   fl_wr_q, fl_rd_q;
  logic [CW-1:0]   outstanding_q;

  logic            redirect, req, valid, grant, push, pop;
  logic [SW-1:0]   reserved;

  assign redirect = bus.PCSrcE;
  assign reserved = SW'(count_q) + SW'(outstanding_q);
  assign grant    = req & bus.imem_gnt;
  // A response is kept only in RUN with a live request behind it; everything else is dropped.
  assign push     = bus.imem_rvalid && !redirect && (state_q == RUN) && (outstanding_q != '0);
  assign pop      = valid & bus.id_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // FSM: next state and discard bookkeeping
  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    drop_total = SW'(outstanding_q) + SW'(discard_q);
    if (redirect) begin
      if (bus.imem_rvalid && (drop_total != '0)) drop_total = drop_total - SW'(1);
      discard_d = CW'(drop_total);
      state_d   = (drop_total != '0) ? FLUSH : RUN;
    end else if ((state_q == FLUSH) && bus.imem_rvalid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
      if (discard_q == CW'(1)) state_d = RUN;
    end
  end

  // FSM: outputs; the space check reserves a queue slot for every request in flight
  always_comb begin
    req   = 1'b0;
    valid = 1'b0;
    case (state_q)
      RUN:     req = rst && !redirect && (outstanding_q < CW'(MAX_OUTSTANDING))
                     && (reserved < SW'(DEPTH));
      default: req = 1'b0;
    endcase
    valid = (count_q != '0) && !redirect;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fl_wr_q       <= '0;
      fl_rd_q       <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]  <= '0;
        q_ir[i]  <= '0;
        fl_pc[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc_q    <= {bus.PCTarget[XLEN-1:2], 2'b00};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fl_wr_q       <= '0;
      fl_rd_q       <= '0;
      outstanding_q <= '0;
    end else begin
      if (grant) begin
        fetch_pc_q     <= fetch_pc_q + XLEN'(4);
        fl_pc[fl_wr_q] <= fetch_pc_q;
        fl_wr_q        <= fl_wr_q + AW'(1);
      end
      if (push) begin
        q_pc[wr_ptr_q] <= fl_pc[fl_rd_q];
        q_ir[wr_ptr_q] <= bus.imem_rdata;
        wr_ptr_q       <= wr_ptr_q + AW'(1);
        fl_rd_q        <= fl_rd_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      case ({grant, push})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.IF_ID_valid = valid;
  assign bus.IF_ID_IR    = q_ir[rd_ptr_q];
  assign bus.IF_ID_PC    = q_pc[rd_ptr_q];
  assign bus.queue_count = count_q;
  assign dbg_state_o     = state_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] flush_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (valid && !bus.id_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

  // A response with nothing requested and nothing pending to discard is a memory protocol error.
  a_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    bus.imem_rvalid |-> ((outstanding_q != '0) || (discard_q != '0)));

endmodule
